// File: rtl/timer_sched_pkg.sv
// Shared definitions for the multi-channel tick scheduler.
// Register offsets, channel window geometry, CCTRL/CTRL bit positions and the scan FSM encoding.
// Imported by the prescaler, the top level and the bench.
package timer_sched_pkg;

    // Global registers (ADR[5:0])
    localparam logic [5:0] A_CTRL  = 6'h00;
    localparam logic [5:0] A_PRESC = 6'h01;
    localparam logic [5:0] A_PEND  = 6'h02;
    localparam logic [5:0] A_IE    = 6'h03;

    // Channel windows: channel n occupies CH_BASE + CH_STRIDE*n .. +7
    localparam int CH_BASE   = 8;
    localparam int CH_STRIDE = 8;

    // Offsets inside a channel window
    localparam logic [2:0] O_CCTRL = 3'd0;
    localparam logic [2:0] O_RLD0  = 3'd1;
    localparam logic [2:0] O_RLD1  = 3'd2;
    localparam logic [2:0] O_CNT0  = 3'd3;
    localparam logic [2:0] O_CNT1  = 3'd4;

    // CTRL bits
    localparam int B_RUN = 0;
    localparam int B_OVR = 7;

    // CCTRL bits
    localparam int B_EN  = 0;
    localparam int B_PER = 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Base address of channel n's register window
    function automatic logic [5:0] ch_base(input int n);
        return 6'(CH_BASE + CH_STRIDE * n);
    endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Wishbone slave bus bundle for the timer scheduler (8-bit data, 10-bit address).
// Ports: ADR/DATi/WE/CYC/STB driven by the master; DATo/ACK driven by the slave.
// Both ACK and DATo are combinational in the slave, so there are no wait states.
interface timer_sched_if;
    logic [9:0] WB_ADRi;
    logic [7:0] WB_DATi;
    logic [7:0] WB_DATo;
    logic       WB_WEi;
    logic       WB_CYCi;
    logic       WB_STBi;
    logic       WB_ACKo;

    modport master (
        output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        input  WB_DATo, WB_ACKo
    );

    modport slave (
        input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        output WB_DATo, WB_ACKo
    );
endinterface

// File: rtl/timer_sched_presc.sv
// Prescaler and tick latch: emits one tick every PRESC+1 clocks while RUN, parks it in tick_pend.
// Latency: tick_pend rises on the edge where pcnt==PRESC; consumed by the scan FSM one edge later.
// Backpressure: a tick arriving while tick_pend is still held is dropped and raises sticky OVR.
// Ports: i_run/i_presc from CTRL/PRESC, i_consume from the FSM, i_ovr_clr from a CTRL write,
//        o_tick_pend to the FSM, o_ovr to CTRL[7].
module timer_sched_presc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic [7:0] i_presc,
    input  logic       i_consume,
    input  logic       i_ovr_clr,
    output logic       o_tick_pend,
    output logic       o_ovr
);

    logic [7:0] r_pcnt;
    logic       r_tick_pend;
    logic       r_ovr;
    logic       w_tick;

    assign w_tick = i_run && (r_pcnt == i_presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= 8'h00;
        end else if (!i_run || w_tick) begin
            r_pcnt <= 8'h00;
        end else begin
            r_pcnt <= r_pcnt + 8'h01;
        end
    end

    // A tick that finds the latch occupied is lost, even on the edge the FSM
    // consumes the latch: the scan it would start cannot begin until the next edge anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_pend <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (w_tick && !r_tick_pend) begin
                r_tick_pend <= 1'b1;
            end else if (i_consume) begin
                r_tick_pend <= 1'b0;
            end
            // Setting wins over a simultaneous firmware clear so no overrun is ever hidden.
            if (w_tick && r_tick_pend) begin
                r_ovr <= 1'b1;
            end else if (i_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign o_tick_pend = r_tick_pend;
    assign o_ovr       = r_ovr;

endmodule

// File: rtl/timer_sched.sv
// Multi-channel tick scheduler: NCH software timers sharing one 16-bit decrement/compare datapath.
// Latency: a channel is updated 2+idx clocks after its tick; SCHED_INT lags PEND/IE by one clock.
// Backpressure: none on the bus (zero-wait ACK); ticks arriving faster than a full scan set OVR.
// Ports: clk, rst_n (async active-low); bus = Wishbone slave (8-bit data, ADR[5:0] decoded);
//        SCHED_INT = registered OR of PEND&IE; PEND_o = PEND register mirror.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_sched_if.slave   bus,
    output logic           SCHED_INT,
    output logic [NCH-1:0] PEND_o
);

    localparam logic [1:0] LAST_IDX = 2'(NCH - 1);

    // Bus decode
    logic [5:0]     w_adr;
    logic [2:0]     w_off;
    logic           w_wr;
    logic [NCH-1:0] w_ch_hit;
    logic [NCH-1:0] w_cctrl_wr;
    logic [NCH-1:0] w_w1c;
    logic           w_ovr_clr;
    logic [7:0]     w_rdata;
    logic           w_unused_adr;

    // Global registers
    logic           r_run;
    logic [7:0]     r_presc;
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_ie;

    // Channel registers
    logic [NCH-1:0] r_en;
    logic [NCH-1:0] r_per;
    logic [CW-1:0]  r_rld [NCH];
    logic [CW-1:0]  r_cnt [NCH];

    // Scan FSM and shared datapath
    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_idx;
    logic [1:0]     w_idx_nxt;
    logic           w_consume;
    logic           w_scan_vld;
    logic           w_tick_pend;
    logic           w_ovr;
    logic [CW-1:0]  w_cur_cnt;
    logic [CW-1:0]  w_dec;
    logic           w_zero;
    logic [NCH-1:0] w_pend_set;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_adr        = bus.WB_ADRi[5:0];
    assign w_off        = w_adr[2:0];
    assign w_wr         = bus.WB_CYCi & bus.WB_STBi & bus.WB_WEi;
    assign bus.WB_ACKo  = bus.WB_CYCi & bus.WB_STBi;
    assign w_unused_adr = ^bus.WB_ADRi[9:6];
    assign w_ovr_clr    = w_wr && (w_adr == A_CTRL) && bus.WB_DATi[B_OVR];
    assign w_w1c        = (w_wr && (w_adr == A_PEND)) ? bus.WB_DATi[NCH-1:0] : '0;

    always_comb begin
        w_ch_hit   = '0;
        w_cctrl_wr = '0;
        for (int n = 0; n < NCH; n++) begin
            w_ch_hit[n]   = ((w_adr & 6'h38) == ch_base(n));
            w_cctrl_wr[n] = w_wr && w_ch_hit[n] && (w_off == O_CCTRL);
        end
    end

    // ------------------------------------------------------------------
    // Prescaler / tick latch
    // ------------------------------------------------------------------
    timer_sched_presc u_presc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (r_run),
        .i_presc     (r_presc),
        .i_consume   (w_consume),
        .i_ovr_clr   (w_ovr_clr),
        .o_tick_pend (w_tick_pend),
        .o_ovr       (w_ovr)
    );

    // ------------------------------------------------------------------
    // Scan FSM: one channel per clock after each accepted tick
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_consume   = 1'b0;
        w_scan_vld  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick_pend) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = 2'd0;
                    w_consume   = 1'b1;
                end
            end
            SCAN: begin
                w_scan_vld = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Shared decrement/compare on the channel currently addressed by r_idx
    assign w_cur_cnt = r_cnt[r_idx];
    assign w_zero    = (w_cur_cnt == '0);
    assign w_dec     = w_cur_cnt - CW'(1);

    // Expiry flags; a CCTRL write to the scanned channel suppresses its whole scan update.
    always_comb begin
        w_pend_set = '0;
        for (int n = 0; n < NCH; n++) begin
            w_pend_set[n] = w_scan_vld && (r_idx == 2'(n)) && r_en[n] && w_zero && !w_cctrl_wr[n];
        end
    end

    // ------------------------------------------------------------------
    // Global registers and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_presc   <= 8'h00;
            r_ie      <= '0;
            r_pend    <= '0;
            SCHED_INT <= 1'b0;
        end else begin
            if (w_wr && (w_adr == A_CTRL)) begin
                r_run <= bus.WB_DATi[B_RUN];
            end
            if (w_wr && (w_adr == A_PRESC)) begin
                r_presc <= bus.WB_DATi;
            end
            if (w_wr && (w_adr == A_IE)) begin
                r_ie <= bus.WB_DATi[NCH-1:0];
            end
            // Set after clear: an expiry on the same edge as a W1C is never lost.
            r_pend    <= (r_pend & ~w_w1c) | w_pend_set;
            SCHED_INT <= |(r_pend & r_ie);
        end
    end

    assign PEND_o = r_pend;

    // ------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NCH; n++) begin
                r_en[n]  <= 1'b0;
                r_per[n] <= 1'b0;
                r_rld[n] <= '0;
                r_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (w_cctrl_wr[n]) begin
                    r_en[n]  <= bus.WB_DATi[B_EN];
                    r_per[n] <= bus.WB_DATi[B_PER];
                    // Only a rising EN arms the counter; re-writing EN=1 leaves a countdown alone.
                    if (bus.WB_DATi[B_EN] && !r_en[n]) begin
                        r_cnt[n] <= r_rld[n];
                    end
                end else if (w_scan_vld && (r_idx == 2'(n)) && r_en[n]) begin
                    if (!w_zero) begin
                        r_cnt[n] <= w_dec;
                    end else if (r_per[n]) begin
                        r_cnt[n] <= r_rld[n];
                    end else begin
                        r_en[n] <= 1'b0;
                    end
                end
                if (w_wr && w_ch_hit[n] && (w_off == O_RLD0)) begin
                    r_rld[n][7:0] <= bus.WB_DATi;
                end
                if (w_wr && w_ch_hit[n] && (w_off == O_RLD1)) begin
                    r_rld[n][15:8] <= bus.WB_DATi;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational from ADR)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 8'h00;
        case (w_adr)
            A_CTRL: begin
                w_rdata[B_OVR] = w_ovr;
                w_rdata[B_RUN] = r_run;
            end
            A_PRESC: w_rdata = r_presc;
            A_PEND:  w_rdata[NCH-1:0] = r_pend;
            A_IE:    w_rdata[NCH-1:0] = r_ie;
            default: ;
        endcase
        for (int n = 0; n < NCH; n++) begin
            if (w_ch_hit[n]) begin
                case (w_off)
                    O_CCTRL: begin
                        w_rdata[B_EN]  = r_en[n];
                        w_rdata[B_PER] = r_per[n];
                    end
                    O_RLD0:  w_rdata = r_rld[n][7:0];
                    O_RLD1:  w_rdata = r_rld[n][15:8];
                    O_CNT0:  w_rdata = r_cnt[n][7:0];
                    O_CNT1:  w_rdata = r_cnt[n][15:8];
                    default: ;
                endcase
            end
        end
    end

    assign bus.WB_DATo = w_rdata;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: register map, periodic/one-shot timing, overrun,
// bus/scan collisions, reload isolation and mid-scan reset, with hand-computed cycle counts.
module tb_timer_sched;
    import timer_sched_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCHED_INT;
    logic [3:0] PEND_o;
    int         checks  = 0;
    int         errors  = 0;
    int         cyc_cnt = 0;

    timer_sched_if bus ();

    timer_sched #(.NCH(4), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .SCHED_INT (SCHED_INT),
        .PEND_o    (PEND_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write lands on the first posedge after the next negedge; returns 1ns after that edge.
    task automatic wb_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.WB_ADRi = a; bus.WB_DATi = d;
        bus.WB_WEi = 1'b1; bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        @(posedge clk);
        #1;
        bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
    endtask

    task automatic wb_read(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.WB_ADRi = a; bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        #2;
        d = bus.WB_DATo;
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc_cnt < target) @(negedge clk);
    endtask

    task automatic wait_pend(input int b, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (PEND_o[b]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.WB_ADRi = '0; bus.WB_DATi = '0;
        bus.WB_WEi = 1'b0; bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [9:0] addrs [12] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h008, 10'h009,
                                   10'h00B, 10'h014, 10'h01A, 10'h01C, 10'h020, 10'h023};
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            wb_read(addrs[i], d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_read adr=%h got=%h exp=00", addrs[i], d);
            end
        end
        checks++;
        if (SCHED_INT !== 1'b0 || PEND_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs int=%b pend=%h exp int=0 pend=0", SCHED_INT, PEND_o);
        end
        @(negedge clk);
        bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1;
        #1;
        checks++;
        if (bus.WB_ACKo !== 1'b1) begin
            errors++;
            $display("FAIL ack_active got=%b exp=1", bus.WB_ACKo);
        end
        bus.WB_STBi = 1'b0;
        #1;
        checks++;
        if (bus.WB_ACKo !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle got=%b exp=0", bus.WB_ACKo);
        end
        bus.WB_CYCi = 1'b0;
    endtask

    task automatic test_decode;
        logic [7:0] d;
        do_reset();
        wb_write(10'h3C1, 8'h55);          // PRESC through an upper-bit alias
        wb_read(10'h001, d);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL presc_alias got=%h exp=55", d); end
        wb_write(10'h005, 8'hAA);          // unmapped
        wb_read(10'h005, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got=%h exp=00", d); end
        wb_write(10'h022, 8'h5A);          // ch3 RLD1
        wb_read(10'h022, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL rld1_ch3 got=%h exp=5a", d); end
        wb_write(10'h023, 8'h77);          // ch3 CNT0 is read-only
        wb_read(10'h023, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL cnt_readonly got=%h exp=00", d); end
        wb_write(10'h003, 8'hFF);
        wb_read(10'h003, d);
        checks++;
        if (d !== 8'h0F) begin errors++; $display("FAIL ie_width got=%h exp=0f", d); end
    endtask

    task automatic test_reset_midscan;
        logic [7:0] d;
        int c0;
        do_reset();
        wb_write(10'h001, 8'd4);
        wb_write(10'h011, 8'd5);
        wb_write(10'h010, 8'h01);
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wait_until(c0 + 7);                // tick at +5, SCAN entered at +6
        checks++;
        if (dut.r_state !== SCAN) begin errors++; $display("FAIL midscan_state got=%0d exp=%0d", dut.r_state, SCAN); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, IDLE); end
        wb_read(10'h013, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", d); end
        wb_read(10'h010, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_cctrl got=%h exp=00", d); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (PEND_o !== 4'h0) begin errors++; $display("FAIL post_reset_pend got=%h exp=0", PEND_o); end
    endtask

    task automatic test_periodic;
        logic [7:0] d;
        int c0;
        bit seen;
        do_reset();
        wb_write(10'h001, 8'd7);
        wb_write(10'h009, 8'd3);
        wb_write(10'h00A, 8'd0);
        wb_write(10'h003, 8'h01);
        wb_write(10'h008, 8'h03);
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wait_pend(0, 100, seen);
        checks++;
        if (!seen || (cyc_cnt - c0) != 34) begin
            errors++; $display("FAIL periodic_first seen=%0d at=%0d exp=34", seen, cyc_cnt - c0);
        end
        checks++;
        if (SCHED_INT !== 1'b0) begin errors++; $display("FAIL int_lag got=%b exp=0", SCHED_INT); end
        @(negedge clk);
        checks++;
        if (SCHED_INT !== 1'b1) begin errors++; $display("FAIL int_rise got=%b exp=1", SCHED_INT); end
        wb_read(10'h00B, d);
        checks++;
        if (d !== 8'd3) begin errors++; $display("FAIL periodic_reload got=%h exp=03", d); end
        wb_write(10'h002, 8'h01);
        checks++;
        if (PEND_o[0] !== 1'b0) begin errors++; $display("FAIL pend_w1c got=%b exp=0", PEND_o[0]); end
        @(posedge clk);
        #1;
        checks++;
        if (SCHED_INT !== 1'b0) begin errors++; $display("FAIL int_fall got=%b exp=0", SCHED_INT); end
        wait_pend(0, 100, seen);
        checks++;
        if (!seen || (cyc_cnt - c0) != 66) begin
            errors++; $display("FAIL periodic_second seen=%0d at=%0d exp=66", seen, cyc_cnt - c0);
        end
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL periodic_no_ovr got=%h exp=01", d); end
    endtask

    task automatic test_oneshot;
        logic [7:0] d;
        int c0;
        bit seen;
        do_reset();
        wb_write(10'h001, 8'd4);
        wb_write(10'h019, 8'h02);
        wb_write(10'h01A, 8'h01);
        wb_write(10'h003, 8'h04);
        wb_write(10'h018, 8'h01);
        wb_read(10'h01B, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL oneshot_load_lo got=%h exp=02", d); end
        wb_read(10'h01C, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL oneshot_load_hi got=%h exp=01", d); end
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wait_pend(2, 1500, seen);
        checks++;
        if (!seen || (cyc_cnt - c0) != 1299) begin
            errors++; $display("FAIL oneshot_expiry seen=%0d at=%0d exp=1299", seen, cyc_cnt - c0);
        end
        wb_read(10'h018, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL oneshot_en_clear got=%h exp=00", d); end
        wb_read(10'h01B, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL oneshot_cnt got=%h exp=00", d); end
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL safe_presc_ovr got=%h exp=01", d); end
        wb_write(10'h002, 8'h04);
        repeat (60) @(negedge clk);
        checks++;
        if (PEND_o !== 4'h0 || SCHED_INT !== 1'b0) begin
            errors++; $display("FAIL oneshot_rearm pend=%h int=%b exp pend=0 int=0", PEND_o, SCHED_INT);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        do_reset();
        wb_write(10'h001, 8'd1);
        wb_write(10'h000, 8'h01);
        repeat (12) @(negedge clk);
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h81) begin errors++; $display("FAIL ovr_set got=%h exp=81", d); end
        wb_write(10'h000, 8'h00);
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h80) begin errors++; $display("FAIL ovr_sticky got=%h exp=80", d); end
        wb_write(10'h000, 8'h80);
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ovr_clear got=%h exp=00", d); end
        wb_write(10'h000, 8'h01);
        wb_read(10'h000, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL run_as_written got=%h exp=01", d); end
    endtask

    task automatic test_collision;
        logic [7:0] d;
        int c0;
        // W1C on the expiry edge of ch1 (RLD=0 expires on every tick: W+8k+3)
        do_reset();
        wb_write(10'h001, 8'd7);
        wb_write(10'h011, 8'd0);
        wb_write(10'h012, 8'd0);
        wb_write(10'h010, 8'h03);
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wait_until(c0 + 17);
        wb_write(10'h002, 8'h02);          // lands on W+19
        checks++;
        if (PEND_o[1] !== 1'b1) begin errors++; $display("FAIL w1c_vs_set got=%b exp=1", PEND_o[1]); end
        wb_write(10'h002, 8'h02);          // lands on W+20, no expiry
        checks++;
        if (PEND_o[1] !== 1'b0) begin errors++; $display("FAIL w1c_plain got=%b exp=0", PEND_o[1]); end

        // CCTRL write on ch1's scan edge: bus value kept, decrement dropped
        do_reset();
        wb_write(10'h001, 8'd7);
        wb_write(10'h011, 8'd10);
        wb_write(10'h010, 8'h03);
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wait_until(c0 + 17);
        wb_write(10'h010, 8'h01);          // lands on W+19
        wb_write(10'h000, 8'h00);
        wb_read(10'h010, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL cctrl_bus_wins got=%h exp=01", d); end
        wb_read(10'h013, d);
        checks++;
        if (d !== 8'd9) begin errors++; $display("FAIL cctrl_no_dec got=%h exp=09", d); end
    endtask

    task automatic test_reload;
        logic [7:0] d;
        int c0;
        bit seen;
        do_reset();
        wb_write(10'h001, 8'd4);
        wb_write(10'h021, 8'd10);
        wb_write(10'h020, 8'h03);
        wb_write(10'h000, 8'h01);
        c0 = cyc_cnt;
        wb_write(10'h021, 8'd2);
        wait_pend(3, 100, seen);
        checks++;
        if (!seen || (cyc_cnt - c0) != 60) begin
            errors++; $display("FAIL reload_first seen=%0d at=%0d exp=60", seen, cyc_cnt - c0);
        end
        wb_read(10'h023, d);
        checks++;
        if (d !== 8'd2) begin errors++; $display("FAIL reload_value got=%h exp=02", d); end
        wb_write(10'h002, 8'h08);
        wait_pend(3, 100, seen);
        checks++;
        if (!seen || (cyc_cnt - c0) != 75) begin
            errors++; $display("FAIL reload_second seen=%0d at=%0d exp=75", seen, cyc_cnt - c0);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_reset_midscan();
        test_periodic();
        test_oneshot();
        test_overrun();
        test_collision();
        test_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Multi-channel tick scheduler on the peripheral Wishbone bus (8-bit data).
- Shares one 16-bit decrement/compare datapath among NCH virtual timer channels.
- A scan FSM visits the channels one per clock after each prescaled tick.
- Produces per-channel pending flags and one level interrupt to the interrupt controller, so firmware gets several software timers from one block.

Parameters:
- NCH, 4, number of channels (1..4; address map sized for 4).
- CW, 16, channel counter/reload width (fixed at 16 for the 8-bit register map).

Ports:
- clk  in  1  system clock; only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- WB_ADRi  in  10  address; ADR[5:0] decoded, upper bits ignored.
- WB_DATi  in  8  write data.
- WB_DATo  out  8  read data, combinational from ADR.
- WB_WEi  in  1  write enable.
- WB_CYCi  in  1  cycle.
- WB_STBi  in  1  strobe.
- WB_ACKo  out  1  = CYCi&STBi, combinational, zero wait states.
- SCHED_INT  out  1  registered OR over channels of PEND[n]&IE[n].
- PEND_o  out  NCH  mirror of PEND register.

Behaviour:
- Write strobe: wr = CYC&STB&WE. All register writes occur on posedge clk.
- Register map:
  - 0x00 CTRL: [0] RUN, [7] OVR (sticky; write 1 to clear).
  - 0x01 PRESC.
  - 0x02 PEND: W1C.
  - 0x03 IE.
  - Channel n at base 0x08+8n: +0 CCTRL ([0] EN, [1] PERIODIC); +1 RLD0; +2 RLD1; +3 CNT0 (read-only); +4 CNT1 (read-only).
  - Unmapped addresses read 0x00; writes to them are ignored.
- Reset (rst_n=0, async): all registers, counters, PEND, OVR, FSM and SCHED_INT go to 0; FSM=IDLE; WB_DATo follows the decode of the zeroed registers.
- Prescaler:
  - 8-bit pcnt counts while RUN=1; at pcnt==PRESC it wraps to 0 and pulses tick. One tick every PRESC+1 clocks.
  - RUN=0 holds pcnt at 0.
- tick_pend latch:
  - tick sets tick_pend.
  - If tick occurs while tick_pend is already 1, OVR is set and the tick is dropped.
  - FSM IDLE with tick_pend=1 goes to SCAN next edge, with idx=0; tick_pend clears on that edge.
- SCAN, one channel per clock at idx, in order 0..NCH-1:
  - EN=0: no change.
  - EN=1, CNT!=0: CNT <= CNT-1.
  - EN=1, CNT==0: set PEND[idx]. If PERIODIC, CNT <= RLD; otherwise EN <= 0 and CNT stays 0.
  - After idx=NCH-1, go to IDLE. The earliest next SCAN entry is the following edge.
  - Period = RLD+1 ticks. Minimum safe PRESC = NCH; a smaller value makes OVR occur.
- Enabling: writing CCTRL with EN 0->1 loads CNT <= {RLD1,RLD0} on the same edge. Writing EN 1->1 leaves CNT unchanged.
- Collisions:
  - A bus write to CCTRL of the channel being scanned in the same cycle: the bus write wins and the scan update for that channel is discarded.
  - PEND W1C and a scan set on the same bit in the same cycle: set wins.
- RLD writes take effect on the next reload or enable; they never alter a running CNT.
- Clearing RUN mid-scan: the current scan completes; tick_pend is kept.
- SCHED_INT is registered and lags the PEND/IE change by 1 clock.
- CNT read is not atomic across CNT0/CNT1. Firmware must pause with RUN=0 to obtain a coherent 16-bit value.

Decomposition:
- Package timer_sched_pkg: register offsets (CTRL, PRESC, PEND, IE, CH_BASE, CH_STRIDE=8, CCTRL/RLD0/RLD1/CNT0/CNT1), CCTRL bit indices, FSM state enum {IDLE, SCAN}.
- One natural sub-module: timer_sched_presc (prescaler plus tick_pend/OVR latch).
- The shared decrement/compare datapath and the channel register arrays stay in the top module.

Test Plan:
- Reset: after rst_n low, all reads return 0x00 and SCHED_INT=0. Asserting rst_n mid-SCAN returns the FSM to IDLE and clears CNT.
- Periodic: PRESC=7, ch0 RLD=3, PERIODIC=1, EN=1, IE=1, RUN=1 -> PEND[0] sets every 32 clocks, SCHED_INT follows 1 clock later, CNT reloads to 3.
- One-shot: ch2 RLD=0x0102, EN=1 -> PEND[2] sets once after 259 ticks; EN reads 0; no further PEND after W1C.
- Overrun: PRESC=1, NCH=4 -> CTRL[7]=1 within 2 ticks. Writing 0x80 to CTRL clears OVR while RUN remains as written.
- Collision: W1C PEND[1] on the same edge ch1 expires -> PEND[1] remains 1. Writing CCTRL ch1 on its scan cycle -> bus value kept and the decrement is absent.
- Reload isolation: change RLD of running ch3 from 10 to 2 -> the current countdown finishes at 10, the next period is 3 ticks.
